// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants, write-back selects and memory FSM state encoding.
package pipe_pkg;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 4;
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_NPC = 2'b10;
    typedef logic [0:0] mem_state_t;
    localparam mem_state_t ST_IDLE = 1'b0;
    localparam mem_state_t ST_WAIT = 1'b1;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ack bus between the MEM stage (master) and memory (slave).
interface mem_stage_if #(parameter int DATA_W = 32);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;
    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ack);
    modport slave  (input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ack);
endinterface

// File: rtl/mem_access_fsm.sv
// mem_access_fsm: IDLE/WAIT handshake controller producing request, stall and completion.
// Optional wait-cycle timeout with mem_err pulse is built when MEM_TIMEOUT_EN is defined.
module mem_access_fsm import pipe_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_mem_op,
    input  logic i_ack,
    output logic o_req,
    output logic o_stall,
    output logic o_done,
    output logic o_err
);
    mem_state_t r_state;
    logic       w_timeout;
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    // An ack in the timeout cycle wins, so the abort only fires without one.
    assign w_timeout = (r_state == ST_WAIT) && !i_ack && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            r_cnt <= (r_state == ST_WAIT) ? r_cnt + 1'b1 : '0;
        end
    end
    assign o_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif
    // Reset gates req/stall combinationally so an in-flight access is dropped at once.
    assign o_req   = rst_n && i_mem_op && !w_timeout;
    assign o_stall = rst_n && i_mem_op && !i_ack && !w_timeout;
    assign o_done  = !i_mem_op || i_ack;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else if (r_state == ST_IDLE)
            r_state <= (i_mem_op && !i_ack) ? ST_WAIT : ST_IDLE;
        else
            r_state <= (i_ack || w_timeout) ? ST_IDLE : ST_WAIT;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage - data-memory access, write-back select and MEM/WB register.
// Define MEM_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES without an ack.
module mem_stage import pipe_pkg::*; #(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWr_EX,
    input  logic                  MemWr_EX,
    input  logic                  MemRd_EX,
    input  logic [1:0]            WBdata_EX,
    input  logic [DATA_W-1:0]     ALUout,
    input  logic [DATA_W-1:0]     D,
    input  logic [DATA_W-1:0]     npc3,
    input  logic [REG_ADDR_W-1:0] rd3,
    mem_stage_if.master           dmem,
    output logic                  mem_stall,
    output logic                  RegWr_WB,
    output logic [REG_ADDR_W-1:0] rd4,
    output logic [DATA_W-1:0]     WBvalue,
    output logic                  mem_err
);
    logic              w_done;
    logic [DATA_W-1:0] w_wb_val;
    logic              r_regwr;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_wb_val;

    mem_access_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_mem_op (MemRd_EX || MemWr_EX),
        .i_ack    (dmem.dmem_ack),
        .o_req    (dmem.dmem_req),
        .o_stall  (mem_stall),
        .o_done   (w_done),
        .o_err    (mem_err)
    );

    // Store wins when both load and store are set.
    assign dmem.dmem_we    = MemWr_EX;
    assign dmem.dmem_addr  = ALUout;
    assign dmem.dmem_wdata = D;
    assign w_wb_val = (WBdata_EX == WB_MEM) ? dmem.dmem_rdata :
                      (WBdata_EX == WB_NPC) ? npc3 : ALUout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwr  <= 1'b0;
            r_rd     <= '0;
            r_wb_val <= '0;
        end else if (w_done) begin
            r_regwr  <= RegWr_EX;
            r_rd     <= rd3;
            r_wb_val <= w_wb_val;
        end else begin
            r_regwr  <= 1'b0;
        end
    end

    assign RegWr_WB = r_regwr;
    assign rd4      = r_rd;
    assign WBvalue  = r_wb_val;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with hand-computed expectations.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWr_EX = 1'b0, MemWr_EX = 1'b0, MemRd_EX = 1'b0;
    logic [1:0]  WBdata_EX = 2'b00;
    logic [31:0] ALUout = '0, D = '0, npc3 = '0;
    logic [3:0]  rd3 = '0;
    logic        mem_stall, RegWr_WB, mem_err;
    logic [3:0]  rd4;
    logic [31:0] WBvalue;
    int          n_vec = 0;
    int          n_err = 0;

    mem_stage_if #(.DATA_W(32)) dmem ();

    mem_stage #(.DATA_W(32), .REG_ADDR_W(4), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .RegWr_EX(RegWr_EX), .MemWr_EX(MemWr_EX), .MemRd_EX(MemRd_EX),
        .WBdata_EX(WBdata_EX), .ALUout(ALUout), .D(D), .npc3(npc3), .rd3(rd3), .dmem(dmem),
        .mem_stall(mem_stall), .RegWr_WB(RegWr_WB), .rd4(rd4), .WBvalue(WBvalue), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic op(input logic rw, input logic wr, input logic rd, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] d, input logic [31:0] npc, input logic [3:0] r);
        RegWr_EX = rw; MemWr_EX = wr; MemRd_EX = rd; WBdata_EX = sel;
        ALUout = alu; D = d; npc3 = npc; rd3 = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        dmem.dmem_ack = 1'b0;
        dmem.dmem_rdata = '0;
        #3;
        chk("rst_regwr", 32'(RegWr_WB), 32'd0);
        chk("rst_rd4", 32'(rd4), 32'd0);
        chk("rst_wbvalue", WBvalue, 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_req", 32'(dmem.dmem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // ALU op
        op(1'b1, 1'b0, 1'b0, 2'b00, 32'h5, 32'h0, 32'h0, 4'd3);
        #1;
        chk("alu_req", 32'(dmem.dmem_req), 32'd0);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("alu_regwr", 32'(RegWr_WB), 32'd1);
        chk("alu_rd4", 32'(rd4), 32'd3);
        chk("alu_wb", WBvalue, 32'h5);
        // zero-wait load
        op(1'b1, 1'b0, 1'b1, 2'b01, 32'h10, 32'h0, 32'h0, 4'd7);
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_req", 32'(dmem.dmem_req), 32'd1);
        chk("ld_we", 32'(dmem.dmem_we), 32'd0);
        chk("ld_addr", dmem.dmem_addr, 32'h10);
        chk("ld_stall", 32'(mem_stall), 32'd0);
        tick();
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'h0;
        chk("ld_wb", WBvalue, 32'hDEAD_BEEF);
        chk("ld_rd4", 32'(rd4), 32'd7);
        chk("ld_regwr", 32'(RegWr_WB), 32'd1);
        // store with three stall cycles
        op(1'b0, 1'b1, 1'b0, 2'b00, 32'h20, 32'h1234, 32'h0, 4'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_stall", 32'(mem_stall), 32'd1);
            chk("st_req", 32'(dmem.dmem_req), 32'd1);
            chk("st_we", 32'(dmem.dmem_we), 32'd1);
            chk("st_addr", dmem.dmem_addr, 32'h20);
            chk("st_wdata", dmem.dmem_wdata, 32'h1234);
            tick();
            chk("st_bubble", 32'(RegWr_WB), 32'd0);
            chk("st_rd4_hold", 32'(rd4), 32'd7);
            chk("st_wb_hold", WBvalue, 32'hDEAD_BEEF);
        end
        dmem.dmem_ack = 1'b1;
        #1;
        chk("st_ack_stall", 32'(mem_stall), 32'd0);
        chk("st_ack_req", 32'(dmem.dmem_req), 32'd1);
        tick();
        dmem.dmem_ack = 1'b0;
        chk("st_done_regwr", 32'(RegWr_WB), 32'd0);
        chk("st_done_rd4", 32'(rd4), 32'd2);
        chk("st_done_wb", WBvalue, 32'h20);
        // JAL back-to-back, stray ack with no mem op ignored
        op(1'b1, 1'b0, 1'b0, 2'b10, 32'h99, 32'h0, 32'h40, 4'd15);
        dmem.dmem_ack = 1'b1;
        #1;
        chk("jal_req", 32'(dmem.dmem_req), 32'd0);
        chk("jal_stall", 32'(mem_stall), 32'd0);
        tick();
        dmem.dmem_ack = 1'b0;
        chk("jal_wb", WBvalue, 32'h40);
        chk("jal_rd4", 32'(rd4), 32'd15);
        // reserved select falls back to ALUout; both rd+wr acts as a store
        op(1'b1, 1'b1, 1'b1, 2'b11, 32'h77, 32'h55, 32'h40, 4'd4);
        #1;
        chk("both_we", 32'(dmem.dmem_we), 32'd1);
        chk("both_stall", 32'(mem_stall), 32'd1);
        dmem.dmem_ack = 1'b1;
        #1;
        tick();
        dmem.dmem_ack = 1'b0;
        chk("sel11_wb", WBvalue, 32'h77);
        chk("sel11_regwr", 32'(RegWr_WB), 32'd1);
        // reset during a waiting load
        op(1'b1, 1'b0, 1'b1, 2'b01, 32'h30, 32'h0, 32'h0, 4'd9);
        tick();
        chk("rw_stall_wait", 32'(mem_stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_req", 32'(dmem.dmem_req), 32'd0);
        chk("rw_stall", 32'(mem_stall), 32'd0);
        chk("rw_regwr", 32'(RegWr_WB), 32'd0);
        chk("rw_rd4", 32'(rd4), 32'd0);
        chk("rw_wb", WBvalue, 32'd0);
        tick();
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h5555_5555;
        tick();
        chk("late_ack_wb", WBvalue, 32'd0);
        chk("late_ack_rd4", 32'(rd4), 32'd0);
        dmem.dmem_ack = 1'b0;
        op(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_stall", 32'(mem_stall), 32'd0);
        chk("post_rst_err", 32'(mem_err), 32'd0);
`ifdef MEM_TIMEOUT_EN
        op(1'b1, 1'b0, 1'b1, 2'b01, 32'h44, 32'h0, 32'h0, 4'd5);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_stall", 32'(mem_stall), 32'd1);
            chk("to_err_low", 32'(mem_err), 32'd0);
            tick();
        end
        #1;
        chk("to_drop_stall", 32'(mem_stall), 32'd0);
        chk("to_drop_req", 32'(dmem.dmem_req), 32'd0);
        tick();
        op(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 4'd0);
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_bubble", 32'(RegWr_WB), 32'd0);
        tick();
        chk("to_err_pulse", 32'(mem_err), 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
